// File: rtl/twiddle_pkg.sv
// Shared types and constants for the twiddle-factor sequencer.
package twiddle_pkg;

    // Largest FFT size exponent the sequencer accepts.
    localparam int LOG2N_MAX = 9;

    // Width of the stage counter, the log2n input and the tw_stage output.
    localparam int STAGE_W = 4;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/twiddle_addr_gen.sv
// Twiddle index generator: k = (j & (2^s - 1)) << (log2n - 1 - s).
module twiddle_addr_gen
    import twiddle_pkg::*;
#(
    parameter int JW = 9,
    parameter int AW = 9
) (
    input  logic [STAGE_W-1:0] s,
    input  logic [JW-1:0]      j,
    input  logic [STAGE_W-1:0] log2n,
    output logic [AW-1:0]      k
);

    localparam int XW = (AW > JW) ? AW : JW;

    logic [JW-1:0]      mask;
    logic [JW-1:0]      masked;
    logic [STAGE_W-1:0] shift;
    logic [XW-1:0]      shifted;

    // Low s bits of j select the position within the current stage's group.
    genvar gi;
    generate
        for (gi = 0; gi < JW; gi++) begin : g_mask
            assign mask[gi] = (gi < int'(s));
        end
    endgenerate

    assign masked  = j & mask;
    // Outside RUN this can wrap to a large shift, which simply yields k = 0.
    assign shift   = log2n - STAGE_W'(1) - s;
    assign shifted = XW'(masked) << shift;
    assign k       = AW'(shifted);

endmodule

// File: rtl/twiddle_seq.sv
// Twiddle-factor sequencer: streams RAM twiddles in FFT stage order and
// multiplexes a loader write port onto the same external RAM while idle.
module twiddle_seq #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 360,
    parameter int LOG2N_MAX = twiddle_pkg::LOG2N_MAX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               log2n,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [WIDTH-1:0]         ld_re,
    input  logic [WIDTH-1:0]         ld_im,
    output logic                     ld_ready,
    output logic                     ram_we,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic [WIDTH-1:0]         ram_din_re,
    output logic [WIDTH-1:0]         ram_din_im,
    input  logic [WIDTH-1:0]         ram_dout_re,
    input  logic [WIDTH-1:0]         ram_dout_im,
    output logic                     tw_valid,
    input  logic                     tw_ready,
    output logic [WIDTH-1:0]         tw_re,
    output logic [WIDTH-1:0]         tw_im,
    output logic [$clog2(DEPTH)-1:0] tw_k,
    output logic [3:0]               tw_stage,
    output logic                     tw_last
);
    import twiddle_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int JW = LOG2N_MAX;
    localparam logic [STAGE_W-1:0] L2_MAX  = STAGE_W'(LOG2N_MAX);
    localparam logic [AW:0]        DEPTH_L = (AW + 1)'(DEPTH);

    state_t              state_reg, state_next;
    logic [STAGE_W-1:0]  log2n_reg;
    logic [STAGE_W-1:0]  s_reg;
    logic [JW-1:0]       j_reg;
    logic                tw_valid_reg, tw_last_reg;
    logic [WIDTH-1:0]    tw_re_reg, tw_im_reg;
    logic [AW-1:0]       tw_k_reg;
    logic [STAGE_W-1:0]  tw_stage_reg;
    logic                done_reg, err_reg;

    logic                start_ok, load, accept, j_wrap, last_item, ld_ok;
    logic [JW-1:0]       j_max;
    logic [AW-1:0]       k;

    twiddle_addr_gen #(.JW(JW), .AW(AW)) u_addr_gen (
        .s     (s_reg),
        .j     (j_reg),
        .log2n (log2n_reg),
        .k     (k)
    );

    assign start_ok  = start && (log2n != '0) && (log2n <= L2_MAX);
    assign load      = (state_reg == RUN) && (!tw_valid_reg || tw_ready);
    assign accept    = tw_valid_reg && tw_ready;
    assign j_max     = (JW'(1) << (log2n_reg - STAGE_W'(1))) - JW'(1);
    assign j_wrap    = (j_reg == j_max);
    assign last_item = (s_reg == log2n_reg - STAGE_W'(1)) && j_wrap;
    assign ld_ok     = ld_we && (state_reg == IDLE) && ({1'b0, ld_addr} < DEPTH_L);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: accept a valid start, finish on the last load, leave DRAIN on its acceptance.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (load && last_item) state_next = DRAIN;
            DRAIN:   if (accept && tw_last_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state: status flags and the RAM port mux (loader write vs. twiddle read).
    always_comb begin
        busy       = (state_reg == RUN) || (state_reg == DRAIN);
        ld_ready   = (state_reg == IDLE);
        ram_we     = rst_n && ld_ok;
        ram_addr   = ram_we ? ld_addr : k;
        ram_din_re = ld_re;
        ram_din_im = ld_im;
    end

    // Counters, output register and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            log2n_reg    <= '0;
            s_reg        <= '0;
            j_reg        <= '0;
            tw_valid_reg <= 1'b0;
            tw_last_reg  <= 1'b0;
            tw_re_reg    <= '0;
            tw_im_reg    <= '0;
            tw_k_reg     <= '0;
            tw_stage_reg <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= (state_reg == DRAIN) && accept && tw_last_reg;
            err_reg  <= (state_reg == IDLE) && start && !start_ok;

            if ((state_reg == IDLE) && start_ok) begin
                log2n_reg <= log2n;
                s_reg     <= '0;
                j_reg     <= '0;
            end else if (load) begin
                if (j_wrap) begin
                    j_reg <= '0;
                    s_reg <= s_reg + STAGE_W'(1);
                end else begin
                    j_reg <= j_reg + JW'(1);
                end
            end

            if (load) begin
                tw_valid_reg <= 1'b1;
                tw_re_reg    <= ram_dout_re;
                tw_im_reg    <= ram_dout_im;
                tw_k_reg     <= k;
                tw_stage_reg <= s_reg;
                tw_last_reg  <= last_item;
            end else if (accept) begin
                tw_valid_reg <= 1'b0;
            end
        end
    end

    assign done     = done_reg;
    assign err      = err_reg;
    assign tw_valid = tw_valid_reg;
    assign tw_last  = tw_last_reg;
    assign tw_re    = tw_re_reg;
    assign tw_im    = tw_im_reg;
    assign tw_k     = tw_k_reg;
    assign tw_stage = tw_stage_reg;

endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq with a behavioural external RAM.
module tb_twiddle_seq;

    localparam int WIDTH = 32;
    localparam int DEPTH = 360;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             rst_n, start, busy, done, err;
    logic [3:0]       log2n;
    logic             ld_we, ld_ready, ram_we;
    logic [AW-1:0]    ld_addr, ram_addr, tw_k;
    logic [WIDTH-1:0] ld_re, ld_im, ram_din_re, ram_din_im, ram_dout_re, ram_dout_im;
    logic             tw_valid, tw_ready, tw_last;
    logic [WIDTH-1:0] tw_re, tw_im;
    logic [3:0]       tw_stage;

    typedef struct {
        logic [AW-1:0]    k;
        logic [3:0]       stage;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             last;
    } exp_t;

    exp_t sb[$];

    logic [WIDTH-1:0] ram_re [0:511];
    logic [WIDTH-1:0] ram_im [0:511];
    logic [WIDTH-1:0] ref_re [0:511];
    logic [WIDTH-1:0] ref_im [0:511];

    int n_checks = 0;
    int n_pass   = 0;
    int done_count, acc_count, gap_count;
    bit seq_done, done_exp, held, gap_track;
    logic [AW-1:0]    h_k;
    logic [3:0]       h_stage;
    logic [WIDTH-1:0] h_re, h_im;
    logic             h_last;

    twiddle_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG2N_MAX(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .log2n(log2n),
        .busy(busy), .done(done), .err(err),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_re(ld_re), .ld_im(ld_im), .ld_ready(ld_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din_re(ram_din_re), .ram_din_im(ram_din_im),
        .ram_dout_re(ram_dout_re), .ram_dout_im(ram_dout_im),
        .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
        .tw_k(tw_k), .tw_stage(tw_stage), .tw_last(tw_last)
    );

    always #5 clk = ~clk;

    // External twiddle RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_re[ram_addr] <= ram_din_re;
            ram_im[ram_addr] <= ram_din_im;
        end
    end
    assign ram_dout_re = ram_re[ram_addr];
    assign ram_dout_im = ram_im[ram_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Output monitor: pops the scoreboard on every accepted item, checks stall stability and done.
    always @(negedge clk) begin
        if (!rst_n) begin
            held     = 1'b0;
            done_exp = 1'b0;
            gap_track = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 64'(tw_valid), 64'd1);
                check("stall_k",     64'(tw_k),     64'(h_k));
                check("stall_stage", 64'(tw_stage), 64'(h_stage));
                check("stall_re",    64'(tw_re),    64'(h_re));
                check("stall_im",    64'(tw_im),    64'(h_im));
                check("stall_last",  64'(tw_last),  64'(h_last));
            end
            held = 1'b0;
            if (done_exp) begin
                check("done_pulse", 64'(done), 64'd1);
                done_exp = 1'b0;
            end
            if (done) begin
                done_count++;
                seq_done = 1'b1;
            end
            if (gap_track && !tw_valid) gap_count++;
            if (tw_valid && tw_ready) begin
                acc_count++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("item %0d: k=%0d stage=%0d re=%0h im=%0h last=%0d", acc_count, tw_k, tw_stage, tw_re, tw_im, tw_last);
                    check("tw_k",     64'(tw_k),     64'(e.k));
                    check("tw_stage", 64'(tw_stage), 64'(e.stage));
                    check("tw_re",    64'(tw_re),    64'(e.re));
                    check("tw_im",    64'(tw_im),    64'(e.im));
                    check("tw_last",  64'(tw_last),  64'(e.last));
                    if (e.last) done_exp = 1'b1;
                    gap_track = !e.last;
                end
            end else if (tw_valid) begin
                held    = 1'b1;
                h_k     = tw_k;
                h_stage = tw_stage;
                h_re    = tw_re;
                h_im    = tw_im;
                h_last  = tw_last;
            end
        end
    end

    task automatic push_seq(input int l);
        int half;
        exp_t e;
        half = 1 << (l - 1);
        for (int s = 0; s < l; s++) begin
            for (int j = 0; j < half; j++) begin
                e.k     = AW'((j & ((1 << s) - 1)) << (l - 1 - s));
                e.stage = 4'(s);
                e.re    = ref_re[e.k];
                e.im    = ref_im[e.k];
                e.last  = (s == l - 1) && (j == half - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic ram_write(input int a, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        ld_we = 1'b1; ld_addr = AW'(a); ld_re = re; ld_im = im;
        #1;
        check("ld_ready_idle", 64'(ld_ready), 64'd1);
        check("ram_we_idle",   64'(ram_we),   64'd1);
        @(posedge clk); #1;
        ld_we = 1'b0;
        ref_re[a] = re;
        ref_im[a] = im;
    endtask

    task automatic clear_counts();
        seq_done = 1'b0; done_count = 0; acc_count = 0; gap_count = 0;
    endtask

    task automatic run_seq(input int l, input bit toggle, input bit inject);
        int cyc;
        push_seq(l);
        clear_counts();
        start = 1'b1; log2n = 4'(l); tw_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("lat_valid0", 64'(tw_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_valid1", 64'(tw_valid), 64'd1);
        if (toggle) tw_ready = 1'b0;
        cyc = 0;
        while (!seq_done && cyc < 2000) begin
            if (inject && cyc == 3) begin
                ld_we = 1'b1; ld_addr = 9'd2; ld_re = 32'hdead; ld_im = 32'hbeef;
                #1;
                check("ld_ready_run", 64'(ld_ready), 64'd0);
                check("ram_we_run",   64'(ram_we),   64'd0);
            end else begin
                ld_we = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (toggle) tw_ready = ~tw_ready;
        end
        ld_we = 1'b0;
        tw_ready = 1'b1;
        if (!seq_done) check("timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        check("done_single", 64'(done), 64'd0);
        check("busy_end",    64'(busy), 64'd0);
        check("sb_empty",    64'(sb.size()), 64'd0);
        check("done_count",  64'(done_count), 64'd1);
        if (!toggle) check("gap_count", 64'(gap_count), 64'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 512; i++) begin
            ram_re[i] = '0; ram_im[i] = '0; ref_re[i] = '0; ref_im[i] = '0;
        end
        rst_n = 1'b0; start = 1'b0; log2n = '0; ld_we = 1'b0; ld_addr = '0;
        ld_re = '0; ld_im = '0; tw_ready = 1'b1;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_tw_valid", 64'(tw_valid), 64'd0);
        check("rst_tw_last",  64'(tw_last),  64'd0);
        check("rst_ram_we",   64'(ram_we),   64'd0);
        check("rst_tw_k",     64'(tw_k),     64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ld_ready_idle0", 64'(ld_ready), 64'd1);

        // Load RAM[i] = i / -i.
        for (int i = 0; i < 8; i++) ram_write(i, 32'(i), 32'(-i));

        // Out-of-range address is suppressed.
        ld_we = 1'b1; ld_addr = 9'd400; ld_re = 32'h1234; ld_im = 32'h5678;
        #1;
        check("ram_we_oob", 64'(ram_we), 64'd0);
        @(posedge clk); #1;
        ld_we = 1'b0;

        // Rejected starts.
        start = 1'b1; log2n = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_l0",  64'(err),  64'd1);
        check("busy_l0", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("err_l0_pulse", 64'(err), 64'd0);
        start = 1'b1; log2n = 4'd10;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_l10",  64'(err),  64'd1);
        check("busy_l10", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("err_l10_pulse", 64'(err), 64'd0);

        // Full-rate run, then stalled run with a loader write attempt during RUN.
        run_seq(3, 1'b0, 1'b0);
        run_seq(3, 1'b1, 1'b1);
        check("ram_unchanged", 64'(ram_re[2]), 64'd2);

        // log2n = 4 run with a simultaneous loader write, reset after item 5.
        push_seq(4);
        clear_counts();
        start = 1'b1; log2n = 4'd4;
        ld_we = 1'b1; ld_addr = 9'd8; ld_re = 32'h00c0ffee; ld_im = 32'h00000bad;
        #1;
        check("ram_we_with_start",   64'(ram_we),   64'd1);
        check("ram_addr_with_start", 64'(ram_addr), 64'd8);
        @(posedge clk); #1;
        start = 1'b0; ld_we = 1'b0;
        check("ram_wr8",       64'(ram_re[8]), 64'h00c0ffee);
        check("busy_with_ld",  64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b1; log2n = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_while_busy", 64'(err),  64'd0);
        check("busy_ignored",   64'(busy), 64'd1);
        cyc = 0;
        while (acc_count < 5 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (acc_count < 5) check("timeout_rst", 64'd0, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy",     64'(busy),     64'd0);
        check("midrst_tw_valid", 64'(tw_valid), 64'd0);
        check("midrst_tw_stage", 64'(tw_stage), 64'd0);
        check("midrst_tw_re",    64'(tw_re),    64'd0);
        sb.delete();
        rst_n = 1'b1;
        #1;
        check("ld_ready_after_rst", 64'(ld_ready), 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("no_done_after_rst", 64'(done_count), 64'd0);

        // Smallest transform: a single item.
        run_seq(1, 1'b0, 1'b0);
        check("l1_items", 64'(acc_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, twiddle word width (re and im each).
- DEPTH, 360, twiddle RAM depth.
- LOG2N_MAX, 9, largest supported FFT size exponent; 2^(LOG2N_MAX-1) <= DEPTH.
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a twiddle sequence.
- log2n  in  4  FFT size exponent, sampled with start.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  one-cycle pulse when start is rejected.
- ld_we  in  1  loader write request.
- ld_addr  in  $clog2(DEPTH)  loader address.
- ld_re, ld_im  in  WIDTH  loader data.
- ld_ready  out  1  loader write accepted this cycle.
- ram_we  out  1  RAM write enable, shared by re/im RAMs.
- ram_addr  out  $clog2(DEPTH)  RAM address.
- ram_din_re, ram_din_im  out  WIDTH  RAM write data.
- ram_dout_re, ram_dout_im  in  WIDTH  RAM asynchronous read data.
- tw_valid  out  1  twiddle output valid.
- tw_ready  in  1  butterfly consumer ready.
- tw_re, tw_im  out  WIDTH  twiddle value.
- tw_k  out  $clog2(DEPTH)  twiddle index.
- tw_stage  out  4  stage number.
- tw_last  out  1  final item of sequence.

Function
REQ-003 FSM SHALL have states IDLE, RUN and DRAIN; busy SHALL be 1 in RUN and DRAIN.
REQ-004 In IDLE, start with 1 <= log2n <= LOG2N_MAX SHALL latch log2n, clear counters s and j, and enter RUN next cycle.
REQ-005 A start with an out-of-range log2n SHALL pulse err for one cycle and leave the FSM in IDLE.
REQ-006 start SHALL be ignored while busy, with no err pulse.
REQ-007 ld_ready SHALL equal (state==IDLE).
REQ-008 When ld_we and ld_ready are both high, ram_we SHALL be 1, ram_addr SHALL be ld_addr and ram_din SHALL be ld_re/ld_im in the same cycle.
REQ-009 Writes with ld_addr >= DEPTH SHALL be suppressed (ram_we = 0).
REQ-010 ld_we and a valid start in the same IDLE cycle SHALL both be accepted.
REQ-011 When not writing, ram_we SHALL be 0 and ram_addr SHALL be k = (j & (2^s - 1)) << (log2n - 1 - s), computed combinationally from the counters.
REQ-012 Output register load condition: in RUN with (!tw_valid || tw_ready).
REQ-013 On a load, the output register SHALL capture ram_dout_re/im, k, s and the tw_last flag, and tw_valid SHALL become 1 next cycle.
REQ-014 On each load, j SHALL increment; at j = 2^(log2n-1) - 1, j SHALL wrap to 0 and s SHALL increment.
REQ-015 The load of the item (s = log2n-1, j = max) SHALL set tw_last and move the FSM to DRAIN.
REQ-016 Output fields SHALL hold stable while tw_valid && !tw_ready.
REQ-017 tw_valid SHALL clear on acceptance when no new load occurs.
REQ-018 In DRAIN, acceptance of the tw_last item SHALL pulse done in the next cycle and return the FSM to IDLE.
REQ-019 Sequence length SHALL be log2n * 2^(log2n-1) items.
REQ-020 Latency: start sampled at edge 0 -> RUN at edge 1 -> first tw_valid at edge 2.
REQ-021 With tw_ready held at 1, throughput SHALL be 1 item per cycle.

Reset
REQ-022 While rst_n = 0 at a clk edge, the block SHALL reset to IDLE with counters 0 and busy, done, err, tw_valid, tw_last and ram_we all 0.
REQ-023 Reset SHALL also clear tw_re, tw_im, tw_k and tw_stage to 0.
REQ-024 Reset mid-sequence SHALL abandon the sequence with no done pulse; ld_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-025 Package twiddle_pkg SHALL hold the FSM state enum, LOG2N_MAX and the stage-width constant.
REQ-026 The k computation SHALL be a sub-module twiddle_addr_gen (inputs s, j, log2n; output k).
REQ-027 Twiddle re/im RAMs SHALL be instantiated outside this block and share ram_addr/ram_we.

Verification
REQ-028 Load RAM[i] = i (re) and -i (im) for i = 0..7, then start with log2n = 3 and tw_ready = 1 -> 12 items.
- tw_k: 0,0,0,0 | 0,2,0,2 | 0,1,2,3.
- tw_stage: 0 x4, 1 x4, 2 x4; tw_re equals tw_k.
- tw_last on item 12; done one cycle after its acceptance.
REQ-029 Same run with tw_ready toggling 1,0,1,0 -> identical sequence; outputs stable while stalled; no item lost or duplicated.
REQ-030 start with log2n = 0, then with log2n = 10 -> err pulse each time, busy stays 0.
REQ-031 ld_we during RUN -> ld_ready = 0, ram_we = 0, RAM contents unchanged.
- ld_we with ld_addr = 400 in IDLE -> ram_we = 0.
REQ-032 rst_n = 0 after item 5 of a log2n = 4 run -> IDLE next cycle, tw_valid = 0, no done pulse.
- A fresh log2n = 1 start -> single item with k = 0 and tw_last = 1.
